// File: rtl/ps2_host_tx_if.sv
// Host-side command channel of the PS/2 transmitter: byte handshake plus status pulses.
// The master supplies bytes; the slave (ps2_host_tx) reports readiness and outcome.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output tx_done,
        output tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the clock, issues a request-to-send,
// shifts out start/data/parity/stop on device clock falling edges and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10_000,
    parameter int EDGE_TIMEOUT   = 1_500_000
) (
    input  logic            clk,
    input  logic            rst,
    ps2_host_tx_if.slave    tx,
    input  logic            ps2_clk_i,
    input  logic            ps2_data_i,
    output logic            ps2_clk_oe,
    output logic            ps2_data_oe
);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

    localparam int          INH_W    = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [20:0] TO_LAST  = 21'(EDGE_TIMEOUT - 1);

    state_t             r_state;
    logic [INH_W-1:0]   r_inh_cnt;
    logic [20:0]        r_to_cnt;
    logic [3:0]         r_bit_cnt;
    logic [7:0]         r_byte;
    logic               r_parity;
    logic               r_clk_oe;
    logic               r_data_oe;
    logic               r_tx_done;
    logic               r_tx_error;

    logic               r_clk_s1, r_clk_s2, r_clk_prev;
    logic               r_dat_s1, r_dat_s2;
    logic               w_fall;
    logic               w_timeout;

    // Line synchronisers carry no reset: their contents are only acted on after SEND entry.
    always_ff @(posedge clk) begin
        r_clk_s1   <= ps2_clk_i;
        r_clk_s2   <= r_clk_s1;
        r_clk_prev <= r_clk_s2;
        r_dat_s1   <= ps2_data_i;
        r_dat_s2   <= r_dat_s1;
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_timeout = (r_to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_byte     <= '0;
            r_parity   <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
        end else begin
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (tx.tx_valid) begin
                        r_byte    <= tx.tx_data;
                        r_parity  <= ~^tx.tx_data;
                        r_inh_cnt <= '0;
                        r_clk_oe  <= 1'b1;
                        r_state   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (r_inh_cnt == INH_LAST) begin
                        r_data_oe <= 1'b1;
                        r_state   <= REQ;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                REQ: begin
                    // Releasing the clock with data still low is the request-to-send start bit.
                    r_clk_oe  <= 1'b0;
                    r_to_cnt  <= '0;
                    r_bit_cnt <= '0;
                    r_state   <= SEND;
                end
                SEND: begin
                    if (w_fall) begin
                        r_to_cnt  <= '0;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt < 4'd8) begin
                            r_data_oe <= ~r_byte[r_bit_cnt[2:0]];
                        end else if (r_bit_cnt == 4'd8) begin
                            r_data_oe <= ~r_parity;
                        end else begin
                            r_data_oe <= 1'b0;
                            r_state   <= ACK;
                        end
                    end else if (w_timeout) begin
                        r_tx_error <= 1'b1;
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (w_fall) begin
                        r_to_cnt <= '0;
                        if (!r_dat_s2) begin
                            r_state <= WAIT_IDLE;
                        end else begin
                            r_tx_error <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end else if (w_timeout) begin
                        r_tx_error <= 1'b1;
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (r_clk_s2 && r_dat_s2) begin
                        r_tx_done <= 1'b1;
                        r_state   <= IDLE;
                    end else if (w_fall) begin
                        r_to_cnt <= '0;
                    end else if (w_timeout) begin
                        r_tx_error <= 1'b1;
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign tx.tx_ready = (r_state == IDLE);
    assign tx.busy     = (r_state != IDLE);
    assign tx.tx_done  = r_tx_done;
    assign tx.tx_error = r_tx_error;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model on open-collector lines and a
// cycle-level reference model derived from frame timing, compared on every clock.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TO  = 50;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if tx_if ();

    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic ps2_clk_oe, ps2_data_oe;
    logic line_clk, line_dat;
    assign line_clk = dev_clk & ~ps2_clk_oe;
    assign line_dat = dev_dat & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .EDGE_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx         (tx_if),
        .ps2_clk_i  (line_clk),
        .ps2_data_i (line_dat),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int inh_cnt  = 0;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Frame as the device sees it, bit k = k-th bit on the wire: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] expected_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // ---------------- reference model ----------------
    bit         m_act = 0;
    int         m_t = 0, m_n = 0, m_last = 0;
    bit         m_ackd = 0, m_done = 0, m_err = 0;
    logic [7:0] m_byte = '0;
    bit         lc1 = 1, lc2 = 1, lc3 = 1;
    bit         ld1 = 1, ld2 = 1, ld3 = 1;
    bit         chk_en = 0;

    initial begin
        forever begin
            logic       exp_clk, exp_dat;
            logic [10:0] fr;
            bit         fall_now, nd, ne;
            @(negedge clk);
            fr      = expected_frame(m_byte);
            exp_clk = m_act && (m_t <= INH + 1);
            exp_dat = m_act && ((m_t == INH + 1) || (m_t >= INH + 2 && !fr[m_n]));
            if (chk_en) begin
                chk_bit("busy",        tx_if.busy,     m_act);
                chk_bit("tx_ready",    tx_if.tx_ready, !m_act);
                chk_bit("tx_done",     tx_if.tx_done,  m_done);
                chk_bit("tx_error",    tx_if.tx_error, m_err);
                chk_bit("ps2_clk_oe",  ps2_clk_oe,     exp_clk);
                chk_bit("ps2_data_oe", ps2_data_oe,    exp_dat);
            end
            if (tx_if.tx_done === 1'b1)  done_cnt++;
            if (tx_if.tx_error === 1'b1) err_cnt++;
            if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh_cnt++;

            // Next-cycle prediction; the host sees the lines three cycles late.
            fall_now = !lc2 && lc3;
            nd = 0;
            ne = 0;
            if (!rst) begin
                m_act = 0;
            end else if (!m_act) begin
                if (tx_if.tx_valid) begin
                    m_act  = 1;
                    m_t    = 1;
                    m_byte = tx_if.tx_data;
                    m_n    = 0;
                    m_ackd = 0;
                end
            end else begin
                if (m_t >= INH + 2) begin
                    if (m_ackd) begin
                        if (lc2 && ld2) begin nd = 1; m_act = 0; end
                        else if (fall_now) m_last = 0;
                        else if (m_last == TO - 1) begin ne = 1; m_act = 0; end
                        else m_last++;
                    end else if (fall_now) begin
                        if (m_n < 10) begin m_n++; m_last = 0; end
                        else if (!ld2) begin m_ackd = 1; m_last = 0; end
                        else begin ne = 1; m_act = 0; end
                    end else if (m_last == TO - 1) begin
                        ne = 1; m_act = 0;
                    end else begin
                        m_last++;
                    end
                end
                m_t++;
                if (m_t == INH + 2) m_last = 0;
            end
            m_done = nd;
            m_err  = ne;
            lc3 = lc2; lc2 = lc1; lc1 = line_clk;
            ld3 = ld2; ld2 = ld1; ld1 = line_dat;
            cyc++;
            chk_en = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_start(input logic [7:0] d, input bit keep_valid);
        bit ok;
        ok = 0;
        @(posedge clk); #2;
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_if.tx_ready) begin ok = 1; break; end
        end
        @(posedge clk); #2;
        if (!keep_valid) tx_if.tx_valid = 1'b0;
        if (!ok) bound_fail("accept_wait");
    endtask

    task automatic device(input bit ack, input int nedges, output logic [10:0] rx);
        bit ok;
        ok = 0;
        rx = '0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (line_clk && !line_dat) begin ok = 1; break; end
        end
        if (!ok) begin
            bound_fail("device_start_wait");
            return;
        end
        repeat ($urandom_range(3, 15)) @(posedge clk);
        #2;
        for (int k = 0; k < nedges; k++) begin
            rx[k] = line_dat;
            if (k == 10 && ack) begin
                dev_dat = 1'b0;
                repeat (2) @(posedge clk);
                #2;
            end
            dev_clk = 1'b0;
            repeat ($urandom_range(4, 10)) @(posedge clk);
            #2;
            dev_clk = 1'b1;
            repeat ($urandom_range(4, 10)) @(posedge clk);
            #2;
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_if.tx_ready) begin ok = 1; break; end
        end
        if (!ok) bound_fail(name);
        @(posedge clk); #2;
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack, output logic [10:0] rx);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        inh_cnt = 0;
        send_start(d, 0);
        device(ack, 11, rx);
        wait_idle("xfer_idle_wait");
        chk_int("done_pulses",  done_cnt - d0, ack ? 1 : 0);
        chk_int("error_pulses", err_cnt - e0,  ack ? 0 : 1);
        @(negedge clk);
        chk_bit("lines_released", ps2_clk_oe | ps2_data_oe, 1'b0);
        chk_bit("ready_after",    tx_if.tx_ready, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [10:0] rx, rx2;
        logic [7:0]  d;
        bit          ack, ok;
        int          d0, e0, lat;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_bit("reset_ready",  tx_if.tx_ready, 1'b1);
        chk_bit("reset_clk_oe", ps2_clk_oe,     1'b0);
        chk_bit("reset_dat_oe", ps2_data_oe,    1'b0);
        @(posedge clk); #2;
        rst = 1'b1;

        xfer(8'hF4, 1, rx);
        chk_int("frame_F4", int'(rx), 32'h5E8);
        chk_int("inhibit_len", inh_cnt, INH);

        xfer(8'hFF, 1, rx);
        chk_int("frame_FF", int'(rx), 32'h7FE);

        xfer(8'h00, 0, rx);
        chk_int("frame_00_nack", int'(rx), 32'h600);

        // Device never clocks after the request.
        e0 = err_cnt;
        send_start(8'h55, 0);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_if.busy && !ps2_clk_oe) begin ok = 1; break; end
        end
        if (!ok) bound_fail("send_entry_wait");
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (tx_if.tx_error) begin lat = k; break; end
        end
        chk_int("timeout_latency", lat, TO);
        chk_bit("timeout_released", ps2_clk_oe | ps2_data_oe, 1'b0);
        @(posedge clk); #2;
        chk_int("timeout_errors", err_cnt - e0, 1);

        // Reset in the middle of a frame.
        d0 = done_cnt;
        e0 = err_cnt;
        send_start(8'hAA, 0);
        device(1, 4, rx);
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk_bit("midrst_clk_oe", ps2_clk_oe,  1'b0);
        chk_bit("midrst_dat_oe", ps2_data_oe, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        chk_int("midrst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        xfer(8'hAA, 1, rx);
        chk_int("frame_AA", int'(rx), 32'h754);

        // tx_valid held high with new data while busy.
        d0 = done_cnt;
        send_start(8'h81, 1);
        tx_if.tx_data = 8'h3C;
        device(1, 11, rx);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_if.tx_done) begin ok = 1; break; end
        end
        if (!ok) bound_fail("hold_done_wait");
        @(posedge clk); #2;
        tx_if.tx_valid = 1'b0;
        @(negedge clk);
        chk_bit("hold_second_accept", ps2_clk_oe, 1'b1);
        device(1, 11, rx2);
        wait_idle("hold_idle_wait");
        chk_int("frame_81", int'(rx),  32'h702);
        chk_int("frame_3C", int'(rx2), 32'h678);
        chk_int("hold_done_pulses", done_cnt - d0, 2);

        for (int n = 0; n < 8; n++) begin
            d   = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 6)) @(posedge clk);
            xfer(d, ack, rx);
            chk_int("frame_random", int'(rx), int'(expected_frame(d)));
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10_000: clk cycles the PS/2 clock line is held low before a request (100 us at 100 MHz).
REQ-002 Parameter EDGE_TIMEOUT, default 1_500_000: maximum clk cycles allowed between successive device clock falling edges, and before the first one (15 ms).
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 tx_data  in  8  command byte to send to the device.
REQ-006 tx_valid  in  1  request to send tx_data.
REQ-007 tx_ready  out  1  high when a new byte can be accepted.
REQ-008 ps2_clk_i  in  1  sampled PS/2 clock line, asynchronous.
REQ-009 ps2_data_i  in  1  sampled PS/2 data line, asynchronous.
REQ-010 ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release.
REQ-011 ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release.
REQ-012 busy  out  1  transfer in progress.
REQ-013 tx_done  out  1  one-cycle pulse: byte sent and acknowledged.
REQ-014 tx_error  out  1  one-cycle pulse: NACK or timeout.

Function
REQ-015 The block SHALL synchronise ps2_clk_i and ps2_data_i through 2 flops each and detect a clock falling edge as prev=1, cur=0 on the synchronised clock.
REQ-016 The block SHALL accept a byte when tx_valid && tx_ready, latch tx_data, and compute parity = ~^tx_data (odd parity).
REQ-017 tx_ready SHALL equal (state == IDLE); tx_valid in any other state SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-019 IDLE -> INHIBIT on accept; ps2_clk_oe=1 starting the cycle after accept.
REQ-020 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles -> REQ.
REQ-021 REQ: ps2_clk_oe=1 and ps2_data_oe=1 for exactly 1 cycle -> SEND with ps2_clk_oe=0 and ps2_data_oe=1 (start bit).
REQ-022 SEND: falling edges 1-8 SHALL set ps2_data_oe = ~bit[n-1] (data LSB first); edge 9 SHALL set ps2_data_oe = ~parity; edge 10 SHALL set ps2_data_oe=0 (stop bit) -> ACK.
REQ-023 Line updates SHALL take effect the cycle after the detected edge.
REQ-024 ACK: on the next falling edge, synchronised data=0 -> WAIT_IDLE; data=1 -> pulse tx_error, -> IDLE.
REQ-025 WAIT_IDLE: when both synchronised lines are 1 -> pulse tx_done, -> IDLE.
REQ-026 A 21-bit timeout counter SHALL clear on entry to SEND and on every falling edge in SEND/ACK/WAIT_IDLE; on reaching EDGE_TIMEOUT the block SHALL pulse tx_error, release both lines, and go to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 In IDLE both ps2_clk_oe and ps2_data_oe SHALL be 0.
REQ-029 tx_done and tx_error SHALL never assert in the same cycle; each is at most one pulse per accepted byte.
REQ-030 Falling edges detected in IDLE, INHIBIT or REQ SHALL be ignored.

Reset
REQ-031 With rst=0 at a rising clk edge, the block SHALL go to IDLE and clear the bit counter, timeout counter and latched byte.
REQ-032 The outputs during and after reset SHALL be ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_ready=1, tx_done=0, tx_error=0.
REQ-033 Reset mid-transfer SHALL release both lines on the next clk edge with no done or error pulse.

Verification
REQ-034 Send 0xF4 (INHIBIT_CYCLES=20). The device model clocks 11 edges and ACKs.
- Required: clk held low for 20 cycles, then start bit, then bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
- Required: tx_done pulses once.
REQ-035 Send 0xFF. Required: parity bit = 1, tx_done pulses once.
REQ-036 Send 0x00 and the device leaves data high at edge 11. Required: tx_error pulses once, no tx_done, lines released, tx_ready=1.
REQ-037 EDGE_TIMEOUT=50 and the device never clocks. Required: tx_error pulses 50 cycles after SEND entry, both oe=0.
REQ-038 Assert rst=0 after edge 4 of 0xAA. Required: both oe=0 the next cycle, no pulses, and a following 0xAA transfer completes normally.
REQ-039 Hold tx_valid high with new data during a transfer. Required: the data is ignored while busy, and a second byte is accepted only in the first IDLE cycle after tx_done.
